// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions: word sizes and per-stage payload layouts/widths.
package pipe_defs;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REGADDR_W = 5;

  // IF/ID: PC+4 and fetched instruction
  typedef struct packed {
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] instr;
  } ifid_t;

  // ID/EX: PC+4, two register operands, sign-extended immediate, dest candidates, control
  typedef struct packed {
    logic [WORD_W-1:0]    pc4;
    logic [WORD_W-1:0]    rs_val;
    logic [WORD_W-1:0]    rt_val;
    logic [WORD_W-1:0]    imm;
    logic [REGADDR_W-1:0] rt_addr;
    logic [REGADDR_W-1:0] rd_addr;
    logic [8:0]           ctrl;
  } idex_t;

  // EX/MEM: branch target, ALU result, store data, destination, control
  typedef struct packed {
    logic [WORD_W-1:0]    br_target;
    logic                 zero;
    logic [WORD_W-1:0]    alu_res;
    logic [WORD_W-1:0]    st_data;
    logic [REGADDR_W-1:0] dst;
    logic [4:0]           ctrl;
  } exmem_t;

  // MEM/WB: load data, ALU result, destination, write-back control
  typedef struct packed {
    logic [WORD_W-1:0]    ld_data;
    logic [WORD_W-1:0]    alu_res;
    logic [REGADDR_W-1:0] dst;
    logic [1:0]           ctrl;
  } memwb_t;

  localparam int unsigned IFID_W  = $bits(ifid_t);
  localparam int unsigned IDEX_W  = $bits(idex_t);
  localparam int unsigned EXMEM_W = $bits(exmem_t);
  localparam int unsigned MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/pipe_fifo_mem.sv
// DEPTH x WIDTH payload store: one synchronous write port, one asynchronous read port, no reset.
module pipe_fifo_mem #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed payload at the write pointer
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: in-order buffer with valid/ready, hold, flush and starvation counter.
module pipe_stage_elastic
  import pipe_defs::*;
#(
  parameter int unsigned WIDTH = IFID_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       ou_valid,
  input  logic                       ou_ready,
  output logic [WIDTH-1:0]           ou_data,
  input  logic                       flush,
  input  logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             push;
  logic             pop;
  logic             not_empty;

  // Handshake: acceptance depends only on occupancy, never on ou_ready
  assign not_empty = (count != '0);
  assign in_ready  = !rst && !flush && (count < CNT_BITS'(DEPTH));
  assign ou_valid  = not_empty && !hold && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = ou_valid && ou_ready;
  assign ou_data   = not_empty ? rd_data : '0;

  pipe_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers and occupancy; reset and flush both discard all buffered payloads
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles where downstream was ready but got nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (ou_ready && !ou_valid && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model checked every cycle plus directed literal checks.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=2, CNT_W=16
  logic       a_rst = 1'b1, a_iv = 1'b0, a_or = 1'b0, a_fl = 1'b0, a_ho = 1'b0;
  logic [7:0] a_id = 8'h00;
  logic       a_ir, a_ov;
  logic [7:0] a_od;
  logic [1:0] a_cnt;
  logic [15:0] a_bub;

  // Instance B: DEPTH=4, CNT_W=4
  logic       b_rst = 1'b1, b_iv = 1'b0, b_or = 1'b0, b_fl = 1'b0, b_ho = 1'b0;
  logic [7:0] b_id = 8'h00;
  logic       b_ir, b_ov;
  logic [7:0] b_od;
  logic [2:0] b_cnt;
  logic [3:0] b_bub;

  pipe_stage_elastic #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .ou_valid(a_ov), .ou_ready(a_or), .ou_data(a_od), .flush(a_fl), .hold(a_ho),
    .count(a_cnt), .bubble_cnt(a_bub)
  );

  pipe_stage_elastic #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .ou_valid(b_ov), .ou_ready(b_or), .ou_data(b_od), .flush(b_fl), .hold(b_ho),
    .count(b_cnt), .bubble_cnt(b_bub)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending payloads plus a bubble tally per instance
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int ba = 0;
  int bb = 0;

  always @(posedge clk) begin
    logic can_pop, can_push;
    if (a_rst) begin
      qa.delete();
      ba = 0;
    end else begin
      if (a_or && !(qa.size() != 0 && !a_ho && !a_fl) && ba < 65535) ba++;
      if (a_fl) qa.delete();
      else begin
        can_pop  = (qa.size() != 0) && !a_ho && a_or;
        can_push = a_iv && (qa.size() < 2);
        if (can_pop) void'(qa.pop_front());
        if (can_push) qa.push_back(a_id);
      end
    end
    if (b_rst) begin
      qb.delete();
      bb = 0;
    end else begin
      if (b_or && !(qb.size() != 0 && !b_ho && !b_fl) && bb < 15) bb++;
      if (b_fl) qb.delete();
      else begin
        can_pop  = (qb.size() != 0) && !b_ho && b_or;
        can_push = b_iv && (qb.size() < 4);
        if (can_pop) void'(qb.pop_front());
        if (can_push) qb.push_back(b_id);
      end
    end
  end

  // Popped-payload logs for order checks
  logic [7:0] a_seen[$];
  logic [7:0] b_seen[$];
  logic rec_a = 1'b0;
  logic rec_b = 1'b0;

  // Compare every output of both instances against the model mid-cycle
  always @(negedge clk) begin
    chk("a_in_ready", 64'(a_ir), 64'(!a_rst && !a_fl && qa.size() < 2));
    chk("a_ou_valid", 64'(a_ov), 64'(qa.size() != 0 && !a_ho && !a_fl));
    chk("a_ou_data",  64'(a_od), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
    chk("a_count",    64'(a_cnt), 64'(qa.size()));
    chk("a_bubble",   64'(a_bub), 64'(ba));
    chk("b_in_ready", 64'(b_ir), 64'(!b_rst && !b_fl && qb.size() < 4));
    chk("b_ou_valid", 64'(b_ov), 64'(qb.size() != 0 && !b_ho && !b_fl));
    chk("b_ou_data",  64'(b_od), (qb.size() != 0) ? 64'(qb[0]) : 64'd0);
    chk("b_count",    64'(b_cnt), 64'(qb.size()));
    chk("b_bubble",   64'(b_bub), 64'(bb));
    if (rec_a && a_ov && a_or) a_seen.push_back(a_od);
    if (rec_b && b_ov && b_or) b_seen.push_back(b_od);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pat;
    int p;
    int cyc;
    pat = 32'b1011_0010_1110_0101_0011_1000_1101_0110;

    // Reset
    nxt();
    mid();
    chk("rst_a_in_ready", 64'(a_ir), 64'd0);
    chk("rst_a_count", 64'(a_cnt), 64'd0);
    chk("rst_a_ou_valid", 64'(a_ov), 64'd0);
    chk("rst_a_ou_data", 64'(a_od), 64'd0);
    nxt();

    // Stream 0x01..0x08 with ou_ready high
    a_rst = 1'b0; b_rst = 1'b0;
    a_iv = 1'b1; a_id = 8'h01; a_or = 1'b1; rec_a = 1'b1;
    mid();
    chk("first_cycle_in_ready", 64'(a_ir), 64'd1);
    chk("first_cycle_ou_valid", 64'(a_ov), 64'd0);
    nxt();
    for (int k = 2; k <= 8; k++) begin
      a_id = 8'(k);
      if (k == 2) begin
        mid();
        chk("latency_ou_valid", 64'(a_ov), 64'd1);
        chk("latency_ou_data", 64'(a_od), 64'h01);
      end
      nxt();
    end
    a_iv = 1'b0;
    nxt();
    a_or = 1'b0; rec_a = 1'b0;
    mid();
    chk("stream_bubble", 64'(a_bub), 64'd1);
    chk("stream_drained", 64'(a_cnt), 64'd0);
    chk("stream_seen_n", 64'(a_seen.size()), 64'd8);
    for (int i = 0; i < a_seen.size(); i++) chk("stream_order", 64'(a_seen[i]), 64'(i + 1));
    nxt();

    // Full buffer: 0xC refused until a pop frees space
    a_iv = 1'b1; a_id = 8'h0A; nxt();
    a_id = 8'h0B; nxt();
    a_id = 8'h0C;
    mid();
    chk("full_in_ready", 64'(a_ir), 64'd0);
    chk("full_count", 64'(a_cnt), 64'd2);
    nxt();
    a_iv = 1'b0; a_or = 1'b1;
    mid();
    chk("full_pop_in_ready", 64'(a_ir), 64'd0);
    chk("full_pop_data", 64'(a_od), 64'h0A);
    nxt();
    mid();
    chk("after_pop_in_ready", 64'(a_ir), 64'd1);
    chk("after_pop_data", 64'(a_od), 64'h0B);
    chk("after_pop_count", 64'(a_cnt), 64'd1);
    nxt();
    a_or = 1'b0;
    mid();
    chk("drained_count", 64'(a_cnt), 64'd0);
    nxt();

    // Hold for 3 cycles with ou_ready high
    a_iv = 1'b1; a_id = 8'h11; nxt();
    a_id = 8'h22; nxt();
    a_iv = 1'b0; a_ho = 1'b1; a_or = 1'b1;
    repeat (3) begin
      mid();
      chk("hold_ou_valid", 64'(a_ov), 64'd0);
      chk("hold_head", 64'(a_od), 64'h11);
      nxt();
    end
    a_ho = 1'b0;
    mid();
    chk("hold_bubble", 64'(a_bub), 64'd4);
    chk("release_data0", 64'(a_od), 64'h11);
    nxt();
    mid();
    chk("release_data1", 64'(a_od), 64'h22);
    nxt();
    a_or = 1'b0;
    nxt();

    // Flush with a same-cycle push of 0x33
    a_iv = 1'b1; a_id = 8'h44; nxt();
    a_id = 8'h55; nxt();
    a_id = 8'h33; a_fl = 1'b1; a_or = 1'b1;
    mid();
    chk("flush_ou_valid", 64'(a_ov), 64'd0);
    chk("flush_in_ready", 64'(a_ir), 64'd0);
    nxt();
    a_fl = 1'b0; a_iv = 1'b0;
    mid();
    chk("flush_count", 64'(a_cnt), 64'd0);
    chk("flush_ou_data", 64'(a_od), 64'd0);
    chk("flush_bubble_kept", 64'(a_bub), 64'd5);
    nxt();
    a_or = 1'b0;
    nxt();

    // DEPTH=4 stream of 10 payloads under an irregular ou_ready pattern
    rec_b = 1'b1; p = 0; cyc = 0;
    while (b_seen.size() < 10 && cyc < 120) begin
      b_iv = (p < 10);
      b_id = 8'(8'h60 + p);
      b_or = pat[cyc % 32];
      mid();
      if (b_iv && b_ir) p++;
      nxt();
      cyc++;
    end
    b_iv = 1'b0; b_or = 1'b0; rec_b = 1'b0;
    chk("wrap_done", 64'(b_seen.size()), 64'd10);
    for (int i = 0; i < b_seen.size(); i++) chk("wrap_order", 64'(b_seen[i]), 64'(8'h60 + i));
    nxt();

    // Bubble saturation at 15
    b_or = 1'b1;
    repeat (20) nxt();
    mid();
    chk("bubble_sat", 64'(b_bub), 64'd15);
    nxt();

    // Reset mid-stream with three entries buffered
    b_or = 1'b0; b_iv = 1'b1;
    b_id = 8'h71; nxt();
    b_id = 8'h72; nxt();
    b_id = 8'h73; nxt();
    b_iv = 1'b0;
    mid();
    chk("pre_rst_count", 64'(b_cnt), 64'd3);
    nxt();
    b_rst = 1'b1;
    mid();
    chk("rst_in_ready", 64'(b_ir), 64'd0);
    nxt();
    mid();
    chk("rst_count", 64'(b_cnt), 64'd0);
    chk("rst_bubble", 64'(b_bub), 64'd0);
    chk("rst_ou_data", 64'(b_od), 64'd0);
    nxt();
    b_rst = 1'b0;
    mid();
    chk("post_rst_in_ready", 64'(b_ir), 64'd1);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
